// File: rtl/fft_addr_gen_if.sv
// Handshake bundle between the FFT address generator (master) and the butterfly unit (slave).
// FFT_BITREV_LOAD_EN adds the 'loading' flag for the bit-reversed input load phase.
interface fft_addr_gen_if #(
    parameter int LOG2N = 3
) ();
    localparam int SW = (LOG2N > 1) ? $clog2(LOG2N) : 1;

    logic             start;
    logic             ready;
    logic             valid;
    logic [LOG2N-1:0] addr_a;
    logic [LOG2N-1:0] addr_b;
    logic [LOG2N-2:0] twiddle;
    logic [SW-1:0]    stage;
    logic             busy;
    logic             done;
`ifdef FFT_BITREV_LOAD_EN
    logic             loading;

    modport master (input start, ready,
                    output valid, addr_a, addr_b, twiddle, stage, busy, done, loading);
    modport slave  (output start, ready,
                    input valid, addr_a, addr_b, twiddle, stage, busy, done, loading);
`else
    modport master (input start, ready,
                    output valid, addr_a, addr_b, twiddle, stage, busy, done);
    modport slave  (output start, ready,
                    input valid, addr_a, addr_b, twiddle, stage, busy, done);
`endif
endinterface

// File: rtl/fft_addr_gen.sv
// Radix-2 in-place DIT FFT address generator: one butterfly (addr_a, addr_b, twiddle) per handshake.
// Optional macro FFT_BITREV_LOAD_EN adds a LOAD phase presenting n / bit-reverse(n) pairs.
module fft_addr_gen #(
    parameter int LOG2N = 3
) (
    input  logic           clk,
    input  logic           clr,
    fft_addr_gen_if.master bus
);
    localparam int JW = LOG2N - 1;
    localparam int SW = (LOG2N > 1) ? $clog2(LOG2N) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t        state;
    logic [JW-1:0] j;
    logic [SW-1:0] s;
    logic          valid_r, busy_r, done_r;
    logic          adv, j_wrap, last;
    logic [JW-1:0] j_tgl;
    logic [SW-1:0] s_tgl;

    logic [LOG2N-1:0] span, pos, grp, base_a;
    logic [SW-1:0]    tw_sh;

    assign adv = valid_r & bus.ready;

    // Toggle-chain counters: bit i flips when its enable and all lower bits are set.
    always_comb begin
        j_tgl[0] = adv;
        for (int i = 1; i < JW; i++) j_tgl[i] = j_tgl[i-1] & j[i-1];
        j_wrap   = adv & (&j);
        s_tgl[0] = j_wrap;
        for (int i = 1; i < SW; i++) s_tgl[i] = s_tgl[i-1] & s[i-1];
        last     = j_wrap && (s == SW'(LOG2N - 1));
    end

    always_comb begin
        span   = LOG2N'(1) << s;
        pos    = {1'b0, j} & (span - 1'b1);
        grp    = {1'b0, j} >> s;
        base_a = (grp << s) << 1;
        tw_sh  = SW'(LOG2N - 1) - s;
    end

`ifdef FFT_BITREV_LOAD_EN
    logic [LOG2N-1:0] n;
    logic [LOG2N-1:0] n_tgl;
    logic             load_r;

    function automatic logic [LOG2N-1:0] bit_rev(input logic [LOG2N-1:0] x);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) r[i] = x[LOG2N-1-i];
        return r;
    endfunction

    always_comb begin
        n_tgl[0] = adv;
        for (int i = 1; i < LOG2N; i++) n_tgl[i] = n_tgl[i-1] & n[i-1];
    end

    assign bus.loading = load_r;
`endif

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state   <= IDLE;
            j       <= '0;
            s       <= '0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
`ifdef FFT_BITREV_LOAD_EN
            n       <= '0;
            load_r  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        j       <= '0;
                        s       <= '0;
                        valid_r <= 1'b1;
                        busy_r  <= 1'b1;
`ifdef FFT_BITREV_LOAD_EN
                        n       <= '0;
                        load_r  <= 1'b1;
                        state   <= LOAD;
`else
                        state   <= RUN;
`endif
                    end
                end
`ifdef FFT_BITREV_LOAD_EN
                LOAD: begin
                    if (adv) begin
                        n <= n ^ n_tgl;
                        if (&n) begin
                            state  <= RUN;
                            load_r <= 1'b0;
                            j      <= '0;
                            s      <= '0;
                        end
                    end
                end
`endif
                RUN: begin
                    if (adv) begin
                        j <= j ^ j_tgl;
                        s <= s ^ s_tgl;
                        if (last) begin
                            state   <= DONE;
                            valid_r <= 1'b0;
                            done_r  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.valid = valid_r;
    assign bus.busy  = busy_r;
    assign bus.done  = done_r;

    // Address fields are forced to zero outside the active states so idle RAM ports stay quiet.
    always_comb begin
        bus.addr_a  = '0;
        bus.addr_b  = '0;
        bus.twiddle = '0;
        bus.stage   = '0;
        case (state)
            RUN: begin
                bus.addr_a  = base_a | pos;
                bus.addr_b  = base_a | pos | span;
                bus.twiddle = JW'(pos << tw_sh);
                bus.stage   = s;
            end
`ifdef FFT_BITREV_LOAD_EN
            LOAD: begin
                bus.addr_a = n;
                bus.addr_b = bit_rev(n);
            end
`endif
            default: ;
        endcase
    end
endmodule

// File: tb/tb_fft_addr_gen.sv
// Scoreboard bench for fft_addr_gen at LOG2N = 3; expected butterflies come from integer arithmetic.
// Build with FFT_BITREV_LOAD_EN defined to cover the bit-reversed load phase.
module tb_fft_addr_gen;
    localparam int LOG2N = 3;
`ifdef FFT_BITREV_LOAD_EN
    localparam int OFS = 8;
`else
    localparam int OFS = 0;
`endif
    localparam int NB = OFS + 12;

    logic clk = 1'b0;
    logic clr;
    int   n_err = 0;
    int   n_chk = 0;
    int   cyc   = 0;
    int   sb[$];

    fft_addr_gen_if #(.LOG2N(LOG2N)) bus ();
    fft_addr_gen #(.LOG2N(LOG2N)) dut (.clk(clk), .clr(clr), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int pk(input int a, input int b, input int tw, input int s, input int ld);
        return a | (b << 4) | (tw << 8) | (s << 12) | (ld << 16);
    endfunction

    function automatic int observed();
        int ld;
`ifdef FFT_BITREV_LOAD_EN
        ld = int'(bus.loading);
`else
        ld = 0;
`endif
        return pk(int'(bus.addr_a), int'(bus.addr_b), int'(bus.twiddle), int'(bus.stage), ld);
    endfunction

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic push_expected();
`ifdef FFT_BITREV_LOAD_EN
        for (int n = 0; n < 8; n++)
            sb.push_back(pk(n, ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1), 0, 0, 1));
`endif
        for (int s = 0; s < 3; s++) begin
            for (int j = 0; j < 4; j++) begin
                int span, a;
                span = 1 << s;
                a    = (j / span) * 2 * span + (j % span);
                sb.push_back(pk(a, a + span, (j % span) * (4 / span), s, 0));
            end
        end
    endtask

    task automatic run_xfer(input int stall_at, input int stall_n, input bit hold_start, input int abort_at);
        int beat, start_cyc, done_cyc, vcyc, stall_left, exp_v;
        bit fin, aborted;
        push_expected();
        bus.ready  = 1'b1;
        bus.start  = 1'b1;
        start_cyc  = cyc;
        beat       = 0;
        vcyc       = 0;
        stall_left = stall_n;
        fin        = 1'b0;
        aborted    = 1'b0;
        done_cyc   = -1;
        step();
        if (!hold_start) bus.start = 1'b0;
        for (int k = 0; k < 200 && !fin; k++) begin
            if (bus.valid) vcyc++;
            if (bus.done) begin
                done_cyc = cyc;
                fin      = 1'b1;
                check("busy_at_done", int'(bus.busy), 1);
                check("zero_at_done", observed(), 0);
            end else if (bus.valid) begin
                if (beat == stall_at && stall_left > 0) begin
                    bus.ready = 1'b0;
                    stall_left--;
                    check("hold", observed(), (sb.size() > 0) ? sb[0] : -1);
                end else begin
                    bus.ready = 1'b1;
                    if (sb.size() == 0) check("sb_underflow", 1, 0);
                    else begin
                        exp_v = sb.pop_front();
                        check($sformatf("beat%0d", beat), observed(), exp_v);
                    end
                    beat++;
                    if (beat - 1 == abort_at) begin
                        @(posedge clk);
                        #2 clr = 1'b0;
                        #1;
                        check("abort_fields", observed(), 0);
                        check("abort_valid", int'(bus.valid), 0);
                        check("abort_busy", int'(bus.busy), 0);
                        check("abort_done", int'(bus.done), 0);
                        fin     = 1'b1;
                        aborted = 1'b1;
                    end
                end
            end
            if (!fin) step();
        end
        if (!fin) check("timeout", 0, 1);
        if (aborted) begin
            repeat (2) step();
            clr = 1'b1;
            for (int k = 0; k < 5; k++) begin
                step();
                check("no_done_after_abort", int'(bus.done), 0);
                check("idle_after_abort", int'(bus.busy), 0);
            end
            sb.delete();
        end else if (fin) begin
            check("done_latency", done_cyc - start_cyc, NB + 1 + stall_n);
            check("beats", beat, NB);
            check("valid_cycles", vcyc, NB + stall_n);
            check("sb_empty", sb.size(), 0);
            step();
            check("idle_valid", int'(bus.valid), 0);
            check("idle_busy", int'(bus.busy), 0);
            bus.start = 1'b0;
        end
        bus.ready = 1'b1;
    endtask

    initial begin
        clr       = 1'b0;
        bus.start = 1'b0;
        bus.ready = 1'b1;
        step();
        step();
        check("rst_fields", observed(), 0);
        check("rst_valid", int'(bus.valid), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        clr = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check("idle_hold_valid", int'(bus.valid), 0);
            check("idle_hold_busy", int'(bus.busy), 0);
        end

        run_xfer(-1, 0, 1'b0, -1);
        run_xfer(OFS + 5, 5, 1'b0, -1);
        run_xfer(-1, 0, 1'b1, -1);
        run_xfer(-1, 0, 1'b0, -1);
        run_xfer(-1, 0, 1'b0, OFS + 8);
        run_xfer(-1, 0, 1'b0, -1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
